regfile_reader: RTL and testbench

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_reader.sv | 178 +++++++++++++++++
 tb/tb_regfile_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_reader.sv
// regfile_reader: 32 x 32-bit register file with a write-enable vector,
// a two-port registered read with same-edge write bypass, and a serial
// dump engine that streams registers 0..31 over a valid/ready handshake.
// Register 0 is hard-wired to zero.

module regfile_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] WriteEn,
    input  logic [31:0] WriteData,
    input  logic        ReadEn,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic        ReadValid,
    input  logic        DumpStart,
    output logic [31:0] DumpData,
    output logic [4:0]  DumpIndex,
    output logic        DumpValid,
    input  logic        DumpReady,
    output logic        DumpBusy
);

    // Dump sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_OFFER = 2'd2;

    // Value a reader sees at this edge: zero for register 0, the incoming
    // write data if the register is being written on the same edge,
    // otherwise the stored contents.
    function automatic logic [31:0] f_bypass(
        input logic [4:0]  idx,
        input logic [31:0] we,
        input logic [31:0] wd,
        input logic [31:0] stored
    );
        logic [31:0] v;
        if (idx == 5'd0) begin
            v = 32'h0000_0000;
        end else if (we[idx]) begin
            v = wd;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    logic [31:0] r_regs [32];

    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic        r_rv;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_ddata;
    logic [4:0]  r_didx;
    logic        r_dval;
    logic        r_busy;

    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [31:0] w_dump_word;
    logic [1:0]  w_state_nxt;
    logic [4:0]  w_cnt_nxt;
    logic        w_accept;

    // Bypassed read values for both read ports and the dump engine
    always_comb begin
        w_rd1       = f_bypass(ReadRegister1, WriteEn, WriteData, r_regs[ReadRegister1]);
        w_rd2       = f_bypass(ReadRegister2, WriteEn, WriteData, r_regs[ReadRegister2]);
        w_dump_word = f_bypass(r_cnt, WriteEn, WriteData, r_regs[r_cnt]);
        w_accept    = r_dval & DumpReady;
    end

    // Register storage: every flagged register 1..31 loads WriteData
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (WriteEn[i]) begin
                    r_regs[i] <= WriteData;
                end
            end
        end
    end

    // Read port: one-cycle latency, data held while no read is launched
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd1 <= 32'h0000_0000;
            r_rd2 <= 32'h0000_0000;
            r_rv  <= 1'b0;
        end else begin
            r_rv <= ReadEn;
            if (ReadEn) begin
                r_rd1 <= w_rd1;
                r_rd2 <= w_rd2;
            end
        end
    end

    // Dump sequencer next-state and next-index selection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (DumpStart) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = r_cnt;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_OFFER;
            end
            ST_OFFER: begin
                if (w_accept) begin
                    if (r_cnt == 5'd31) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 5'd0;
                    end else begin
                        w_state_nxt = ST_LOAD;
                        w_cnt_nxt   = r_cnt + 5'd1;
                    end
                end else begin
                    w_state_nxt = ST_OFFER;
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    // Dump sequencer state, beat capture and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_ddata <= 32'h0000_0000;
            r_didx  <= 5'd0;
            r_dval  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (r_state == ST_LOAD) begin
                // Snapshot taken here; it stays frozen while the beat waits
                r_ddata <= w_dump_word;
                r_didx  <= r_cnt;
                r_dval  <= 1'b1;
            end else if (w_accept) begin
                r_dval  <= 1'b0;
            end
        end
    end

    assign ReadData1 = r_rd1;
    assign ReadData2 = r_rd2;
    assign ReadValid = r_rv;
    assign DumpData  = r_ddata;
    assign DumpIndex = r_didx;
    assign DumpValid = r_dval;
    assign DumpBusy  = r_busy;

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: directed stimulus, a behavioural model compared
// on every falling edge, and literal expectations for the key scenarios.

module tb_regfile_reader;

    logic        clk;
    logic        reset;
    logic [31:0] WriteEn;
    logic [31:0] WriteData;
    logic        ReadEn;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        ReadValid;
    logic        DumpStart;
    logic [31:0] DumpData;
    logic [4:0]  DumpIndex;
    logic        DumpValid;
    logic        DumpReady;
    logic        DumpBusy;

    int n_pass  = 0;
    int n_total = 0;

    regfile_reader dut (
        .clk           (clk),
        .reset         (reset),
        .WriteEn       (WriteEn),
        .WriteData     (WriteData),
        .ReadEn        (ReadEn),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .ReadValid     (ReadValid),
        .DumpStart     (DumpStart),
        .DumpData      (DumpData),
        .DumpIndex     (DumpIndex),
        .DumpValid     (DumpValid),
        .DumpReady     (DumpReady),
        .DumpBusy      (DumpBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Memory is a plain array; a read or dump capture sees memory after the
    // writes of the same edge. Dump: start -> one edge to fetch, then the
    // beat is offered until accepted; next fetch follows acceptance.
    logic [31:0] m_mem [32];
    logic [31:0] m_rd1, m_rd2, m_ddata;
    logic        m_rv, m_dval, m_busy, m_fetch, m_on;
    logic [4:0]  m_didx, m_next;

    initial m_on = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            m_rd1 = 32'h0; m_rd2 = 32'h0; m_rv = 1'b0;
            m_ddata = 32'h0; m_didx = 5'd0; m_dval = 1'b0;
            m_busy = 1'b0; m_fetch = 1'b0; m_next = 5'd0;
            m_on = 1'b1;
        end else if (m_on) begin
            for (int i = 1; i < 32; i++) if (WriteEn[i]) m_mem[i] = WriteData;
            if (ReadEn) begin
                m_rd1 = m_mem[ReadRegister1];
                m_rd2 = m_mem[ReadRegister2];
            end
            m_rv = ReadEn;
            if (!m_busy) begin
                if (DumpStart) begin
                    m_busy = 1'b1; m_fetch = 1'b1; m_next = 5'd0;
                end
            end else if (m_fetch) begin
                m_fetch = 1'b0; m_dval = 1'b1;
                m_didx = m_next; m_ddata = m_mem[m_next];
            end else if (DumpReady) begin
                m_dval = 1'b0;
                if (m_didx == 5'd31) m_busy = 1'b0;
                else begin m_next = m_didx + 5'd1; m_fetch = 1'b1; end
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (m_on) begin
            chk("m_rd1",   ReadData1, m_rd1);
            chk("m_rd2",   ReadData2, m_rd2);
            chk("m_rv",    32'(ReadValid), 32'(m_rv));
            chk("m_dval",  32'(DumpValid), 32'(m_dval));
            chk("m_didx",  32'(DumpIndex), 32'(m_didx));
            chk("m_ddata", DumpData, m_ddata);
            chk("m_busy",  32'(DumpBusy), 32'(m_busy));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int beats;
        int cycles;
        int busy_cycles;

        // Reset with conflicting activity on every input
        reset = 1'b1; WriteEn = 32'hFFFF_FFFE; WriteData = 32'h5A5A_5A5A;
        ReadEn = 1'b1; ReadRegister1 = 5'd7; ReadRegister2 = 5'd9;
        DumpStart = 1'b1; DumpReady = 1'b0;
        tick; tick;
        reset = 1'b0; WriteEn = 32'h0; ReadEn = 1'b0; DumpStart = 1'b0;
        chk("rst_rd1", ReadData1, 32'h0);
        chk("rst_rv", 32'(ReadValid), 32'h0);
        chk("rst_busy", 32'(DumpBusy), 32'h0);
        chk("rst_dval", 32'(DumpValid), 32'h0);
        ReadEn = 1'b1; ReadRegister1 = 5'd7; ReadRegister2 = 5'd9;
        tick;
        chk("rst_prio_rd1", ReadData1, 32'h0);
        chk("rst_prio_rd2", ReadData2, 32'h0);
        ReadEn = 1'b0;

        // Write then read back
        WriteEn = 32'h0000_0020; WriteData = 32'hDEAD_BEEF;
        tick;
        WriteEn = 32'h0; ReadEn = 1'b1; ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
        tick;
        chk("wr_rd1", ReadData1, 32'hDEAD_BEEF);
        chk("wr_rd2_same", ReadData2, 32'hDEAD_BEEF);
        chk("wr_rv", 32'(ReadValid), 32'h1);

        // Register 0 is never written
        ReadEn = 1'b0; WriteEn = 32'h0000_0001; WriteData = 32'hFFFF_FFFF;
        tick;
        WriteEn = 32'h0; ReadEn = 1'b1; ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        tick;
        chk("r0_rd1", ReadData1, 32'h0);
        chk("r0_rd2", ReadData2, 32'h0);

        // Same-edge bypass on port 2, old data on port 1
        WriteEn = 32'h0000_0100; WriteData = 32'h1234_5678;
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd8;
        tick;
        WriteEn = 32'h0;
        chk("byp_rd2", ReadData2, 32'h1234_5678);
        chk("byp_rd1", ReadData1, 32'hDEAD_BEEF);

        // ReadEn low: valid drops, data holds
        ReadEn = 1'b0;
        tick;
        chk("hold_rv", 32'(ReadValid), 32'h0);
        chk("hold_rd2", ReadData2, 32'h1234_5678);

        // Multi-bit write vector plus bypass of register 0
        WriteEn = 32'h0000_0C01; WriteData = 32'hA5A5_0C0C;
        ReadEn = 1'b1; ReadRegister1 = 5'd0; ReadRegister2 = 5'd11;
        tick;
        WriteEn = 32'h0; ReadRegister1 = 5'd10;
        chk("multi_byp_r0", ReadData1, 32'h0);
        chk("multi_byp_r11", ReadData2, 32'hA5A5_0C0C);
        tick;
        chk("multi_r10", ReadData1, 32'hA5A5_0C0C);
        ReadEn = 1'b0;

        // Preload reg i = i * 0x11111111
        for (int i = 1; i < 32; i++) begin
            WriteEn = 32'h1 << i;
            WriteData = 32'(i) * 32'h1111_1111;
            tick;
        end
        WriteEn = 32'h0;

        // Dump with DumpReady toggling
        DumpReady = 1'b1; DumpStart = 1'b1;
        tick;
        DumpStart = 1'b0;
        beats = 0; cycles = 0;
        while (DumpBusy && cycles < 400) begin
            if (DumpValid && DumpReady) begin
                chk("dump1_idx", 32'(DumpIndex), 32'(beats));
                chk("dump1_data", DumpData, 32'(beats) * 32'h1111_1111);
                beats++;
            end
            tick;
            DumpReady = ~DumpReady;
            cycles++;
        end
        chk("dump1_done", 32'(DumpBusy), 32'h0);
        chk("dump1_beats", 32'(beats), 32'd32);

        // Dump with DumpReady high, restart ignored, reads alongside
        DumpReady = 1'b1; DumpStart = 1'b1;
        tick;
        DumpStart = 1'b0;
        beats = 0; busy_cycles = 0;
        while (DumpBusy && busy_cycles < 200) begin
            busy_cycles++;
            DumpStart = 1'b0;
            if (DumpValid) begin
                beats++;
                if (DumpIndex == 5'd7) DumpStart = 1'b1;
            end
            ReadEn = 1'b1;
            ReadRegister1 = 5'(busy_cycles);
            ReadRegister2 = 5'(31 - busy_cycles);
            tick;
        end
        DumpStart = 1'b0; ReadEn = 1'b0;
        chk("dump2_busy_cycles", 32'(busy_cycles), 32'd64);
        chk("dump2_beats", 32'(beats), 32'd32);
        tick; tick;
        chk("dump2_no_restart", 32'(DumpBusy), 32'h0);

        // Writes during a stalled beat do not disturb the snapshot
        DumpReady = 1'b1; DumpStart = 1'b1;
        tick;
        DumpStart = 1'b0;
        cycles = 0;
        while (!(DumpValid && DumpIndex == 5'd3) && cycles < 50) begin
            tick; cycles++;
        end
        DumpReady = 1'b0;
        chk("dump3_reach3", 32'(DumpIndex), 32'd3);
        WriteEn = 32'h0000_0018; WriteData = 32'hCAFE_0034;
        tick;
        WriteEn = 32'h0;
        tick;
        chk("snap_data", DumpData, 32'h3333_3333);
        chk("snap_idx", 32'(DumpIndex), 32'd3);
        DumpReady = 1'b1;
        tick; tick;
        chk("post_wr_idx", 32'(DumpIndex), 32'd4);
        chk("post_wr_data", DumpData, 32'hCAFE_0034);

        // Abort the dump with reset after beat 10 is accepted
        cycles = 0;
        while (!(DumpValid && DumpIndex == 5'd10) && cycles < 50) begin
            tick; cycles++;
        end
        chk("dump3_reach10", 32'(DumpIndex), 32'd10);
        tick;
        reset = 1'b1; ReadEn = 1'b1; WriteEn = 32'hFFFF_FFFF;
        tick;
        reset = 1'b0; ReadEn = 1'b0; WriteEn = 32'h0;
        chk("abort_busy", 32'(DumpBusy), 32'h0);
        chk("abort_dval", 32'(DumpValid), 32'h0);
        chk("abort_ddata", DumpData, 32'h0);
        chk("abort_didx", 32'(DumpIndex), 32'h0);
        chk("abort_rv", 32'(ReadValid), 32'h0);
        chk("abort_rd1", ReadData1, 32'h0);
        chk("abort_rd2", ReadData2, 32'h0);
        tick; tick; tick;
        chk("abort_no_beats", 32'(DumpValid), 32'h0);
        ReadEn = 1'b1; ReadRegister1 = 5'd4; ReadRegister2 = 5'd31;
        tick;
        ReadEn = 1'b0;
        chk("abort_rd_r4", ReadData1, 32'h0);
        chk("abort_rd_r31", ReadData2, 32'h0);
        chk("abort_rd_rv", 32'(ReadValid), 32'h1);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
